// File: rtl/friscv_dmem_arbiter_if.sv
// Core port, debug port and DMEM-side signals of the data-memory arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface friscv_dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic                  core_req_i;
    logic                  core_we_i;
    logic [BE_WIDTH-1:0]   core_be_i;
    logic [ADDR_WIDTH-1:0] core_addr_i;
    logic [DATA_WIDTH-1:0] core_wdata_i;
    logic                  core_gnt_o;
    logic                  core_rvalid_o;
    logic [DATA_WIDTH-1:0] core_rdata_o;

    logic                  dbg_req_i;
    logic                  dbg_we_i;
    logic [BE_WIDTH-1:0]   dbg_be_i;
    logic [ADDR_WIDTH-1:0] dbg_addr_i;
    logic [DATA_WIDTH-1:0] dbg_wdata_i;
    logic                  dbg_gnt_o;
    logic                  dbg_rvalid_o;
    logic [DATA_WIDTH-1:0] dbg_rdata_o;
    logic                  dbg_lock_i;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [BE_WIDTH-1:0]   mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic [1:0]            arb_state_o;

    modport slave (
        input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        input  dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i, dbg_lock_i,
        output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output arb_state_o
    );

    modport master (
        output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        output dbg_req_i, dbg_we_i, dbg_be_i, dbg_addr_i, dbg_wdata_i, dbg_lock_i,
        input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  arb_state_o
    );
endinterface

// File: rtl/friscv_dmem_arbiter.sv
// Shares the single-port DMEM between the MEM stage and the debug/loader port.
// Grants are combinational; read data is steered back to the port that issued the read.
module friscv_dmem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    friscv_dmem_arbiter_if.slave  bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        CORE_PRI = 2'd0,
        DBG_PRI  = 2'd1,
        DBG_LOCK = 2'd2
    } arb_state_e;

    arb_state_e r_state;
    logic [3:0] r_starve_cnt;
    logic       r_core_rvalid;
    logic       r_dbg_rvalid;

    logic                  w_core_gnt;
    logic                  w_dbg_gnt;
    logic [3:0]            w_starve_next;
    logic                  w_mem_we;
    logic [BE_WIDTH-1:0]   w_mem_be;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    // Grants are gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (rst_n) begin
            case (r_state)
                CORE_PRI: begin
                    w_core_gnt = bus.core_req_i;
                    w_dbg_gnt  = bus.dbg_req_i & ~bus.core_req_i;
                end
                DBG_PRI: begin
                    w_dbg_gnt  = bus.dbg_req_i;
                    w_core_gnt = bus.core_req_i & ~bus.dbg_req_i;
                end
                DBG_LOCK: begin
                    w_dbg_gnt  = bus.dbg_req_i;
                end
                default: begin
                    w_core_gnt = 1'b0;
                    w_dbg_gnt  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_starve_next = 4'd0;
        if (bus.dbg_req_i && !w_dbg_gnt)
            w_starve_next = (r_starve_cnt >= LIMIT) ? LIMIT : r_starve_cnt + 4'd1;
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_core_gnt) begin
            w_mem_we    = bus.core_we_i;
            w_mem_be    = bus.core_be_i;
            w_mem_addr  = bus.core_addr_i;
            w_mem_wdata = bus.core_wdata_i;
        end else if (w_dbg_gnt) begin
            w_mem_we    = bus.dbg_we_i;
            w_mem_be    = bus.dbg_be_i;
            w_mem_addr  = bus.dbg_addr_i;
            w_mem_wdata = bus.dbg_wdata_i;
        end
    end

    // Lock entry needs a debug transfer, which already clears the starve count,
    // so lock entry takes precedence over the starvation promotion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CORE_PRI;
            r_starve_cnt  <= 4'd0;
            r_core_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
        end else begin
            r_core_rvalid <= w_core_gnt & ~bus.core_we_i;
            r_dbg_rvalid  <= w_dbg_gnt & ~bus.dbg_we_i;
            r_starve_cnt  <= w_starve_next;
            case (r_state)
                CORE_PRI: begin
                    if (w_dbg_gnt && bus.dbg_lock_i)
                        r_state <= DBG_LOCK;
                    else if (w_starve_next == LIMIT)
                        r_state <= DBG_PRI;
                end
                DBG_PRI: begin
                    r_state <= (w_dbg_gnt && bus.dbg_lock_i) ? DBG_LOCK : CORE_PRI;
                end
                DBG_LOCK: begin
                    if (!bus.dbg_lock_i)
                        r_state <= CORE_PRI;
                end
                default: r_state <= CORE_PRI;
            endcase
        end
    end

    assign bus.core_gnt_o    = w_core_gnt;
    assign bus.dbg_gnt_o     = w_dbg_gnt;
    assign bus.mem_en_o      = w_core_gnt | w_dbg_gnt;
    assign bus.mem_we_o      = w_mem_we;
    assign bus.mem_be_o      = w_mem_be;
    assign bus.mem_addr_o    = w_mem_addr;
    assign bus.mem_wdata_o   = w_mem_wdata;
    assign bus.core_rvalid_o = r_core_rvalid;
    assign bus.dbg_rvalid_o  = r_dbg_rvalid;
    assign bus.core_rdata_o  = r_core_rvalid ? bus.mem_rdata_i : '0;
    assign bus.dbg_rdata_o   = r_dbg_rvalid ? bus.mem_rdata_i : '0;
    assign bus.arb_state_o   = r_state;
endmodule

// File: tb/tb_friscv_dmem_arbiter.sv
// Directed bench for friscv_dmem_arbiter with a DMEM stub and a priority/lock reference model.
module tb_friscv_dmem_arbiter;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    friscv_dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    friscv_dmem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram    [0:1023];
    logic [31:0] refMem [0:1023];
    logic [31:0] memRdata = 32'h0;
    assign bus.mem_rdata_i = memRdata;

    function automatic logic [31:0] initWord(input int i);
        return 32'hA5A50000 + 32'(i);
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]    = initWord(i);
            refMem[i] = initWord(i);
        end
    end

    // DMEM stub: data appears one cycle after a read enable, noise otherwise.
    always @(posedge clk) begin
        if (bus.mem_en_o && bus.mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_be_o[b]) ram[bus.mem_addr_o[11:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
        end
        memRdata <= (bus.mem_en_o && !bus.mem_we_o) ? ram[bus.mem_addr_o[11:2]] : $urandom();
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: debug is promoted once it has waited LIMIT cycles; lock is held while dbg_lock_i stays high.
    bit          locked = 1'b0;
    int          waitCnt = 0;
    bit          pendValid = 1'b0;
    bit          pendDbg = 1'b0;
    logic [31:0] pendData = 32'h0;
    logic        expCoreGnt = 1'b0;
    logic        expDbgGnt = 1'b0;

    always @(negedge clk) begin
        logic        eWe;
        logic [3:0]  eBe;
        logic [11:0] eAddr;
        logic [31:0] eWd;
        logic [1:0]  eState;
        if (!rst_n) begin
            locked    = 1'b0;
            waitCnt   = 0;
            pendValid = 1'b0;
        end
        expCoreGnt = 1'b0;
        expDbgGnt  = 1'b0;
        if (rst_n) begin
            if (locked) begin
                expDbgGnt = bus.dbg_req_i;
            end else if (waitCnt >= LIMIT) begin
                expDbgGnt  = bus.dbg_req_i;
                expCoreGnt = bus.core_req_i && !bus.dbg_req_i;
            end else begin
                expCoreGnt = bus.core_req_i;
                expDbgGnt  = bus.dbg_req_i && !bus.core_req_i;
            end
        end
        eState = locked ? 2'd2 : ((waitCnt >= LIMIT) ? 2'd1 : 2'd0);
        eWe = 1'b0; eBe = 4'h0; eAddr = 12'h0; eWd = 32'h0;
        if (expCoreGnt) begin
            eWe = bus.core_we_i; eBe = bus.core_be_i; eAddr = bus.core_addr_i; eWd = bus.core_wdata_i;
        end else if (expDbgGnt) begin
            eWe = bus.dbg_we_i; eBe = bus.dbg_be_i; eAddr = bus.dbg_addr_i; eWd = bus.dbg_wdata_i;
        end
        checkOutput("core_gnt", 32'(bus.core_gnt_o), 32'(expCoreGnt));
        checkOutput("dbg_gnt", 32'(bus.dbg_gnt_o), 32'(expDbgGnt));
        checkOutput("mem_en", 32'(bus.mem_en_o), 32'(expCoreGnt | expDbgGnt));
        checkOutput("mem_we", 32'(bus.mem_we_o), 32'(eWe));
        checkOutput("mem_be", 32'(bus.mem_be_o), 32'(eBe));
        checkOutput("mem_addr", 32'(bus.mem_addr_o), 32'(eAddr));
        checkOutput("mem_wdata", bus.mem_wdata_o, eWd);
        checkOutput("arb_state", 32'(bus.arb_state_o), 32'(eState));
        checkOutput("core_rvalid", 32'(bus.core_rvalid_o), 32'(pendValid && !pendDbg));
        checkOutput("dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'(pendValid && pendDbg));
        checkOutput("core_rdata", bus.core_rdata_o, (pendValid && !pendDbg) ? pendData : 32'h0);
        checkOutput("dbg_rdata", bus.dbg_rdata_o, (pendValid && pendDbg) ? pendData : 32'h0);
    end

    always @(posedge clk) begin
        logic        aWe;
        logic [3:0]  aBe;
        logic [9:0]  aWord;
        logic [31:0] aWd;
        if (rst_n) begin
            pendValid = 1'b0;
            if (expCoreGnt || expDbgGnt) begin
                aWe   = expCoreGnt ? bus.core_we_i : bus.dbg_we_i;
                aBe   = expCoreGnt ? bus.core_be_i : bus.dbg_be_i;
                aWord = expCoreGnt ? bus.core_addr_i[11:2] : bus.dbg_addr_i[11:2];
                aWd   = expCoreGnt ? bus.core_wdata_i : bus.dbg_wdata_i;
                if (!aWe) begin
                    pendValid = 1'b1;
                    pendDbg   = expDbgGnt;
                    pendData  = refMem[aWord];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (aBe[b]) refMem[aWord][8*b +: 8] = aWd[8*b +: 8];
                end
            end
            locked  = locked ? bus.dbg_lock_i : (expDbgGnt && bus.dbg_lock_i);
            waitCnt = (bus.dbg_req_i && !expDbgGnt) ? ((waitCnt + 1 > LIMIT) ? LIMIT : waitCnt + 1) : 0;
        end
    end

    task automatic applyStimulus(
        input logic cReq, input logic cWe, input logic [3:0] cBe, input logic [11:0] cAddr, input logic [31:0] cWd,
        input logic dReq, input logic dWe, input logic [3:0] dBe, input logic [11:0] dAddr, input logic [31:0] dWd,
        input logic dLock
    );
        bus.core_req_i = cReq; bus.core_we_i = cWe; bus.core_be_i = cBe;
        bus.core_addr_i = cAddr; bus.core_wdata_i = cWd;
        bus.dbg_req_i = dReq; bus.dbg_we_i = dWe; bus.dbg_be_i = dBe;
        bus.dbg_addr_i = dAddr; bus.dbg_wdata_i = dWd;
        bus.dbg_lock_i = dLock;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyIdle();
        #1 rst_n = 1'b0;

        // Reset: a pending core write is not granted while rst_n is low.
        applyStimulus(1'b1, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rst_core_gnt", 32'(bus.core_gnt_o), 32'd0);
        checkOutput("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
        checkOutput("rst_state", 32'(bus.arb_state_o), 32'd0);
        nextCycle();
        rst_n = 1'b1;

        // Core-only write then read-back.
        @(negedge clk);
        checkOutput("wr_core_gnt", 32'(bus.core_gnt_o), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rd_core_gnt", 32'(bus.core_gnt_o), 32'd1);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkOutput("rd_core_rvalid", 32'(bus.core_rvalid_o), 32'd1);
        checkOutput("rd_core_rdata", bus.core_rdata_o, 32'hDEADBEEF);
        checkOutput("rd_dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'd0);
        nextCycle();

        // Continuous contention: debug wins every fifth cycle.
        applyStimulus(1'b1, 1'b0, 4'h0, 12'h100, 32'h0, 1'b1, 1'b0, 4'h0, 12'h104, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("starve_core_gnt", 32'(bus.core_gnt_o), 32'((i % 5) != 4));
            checkOutput("starve_dbg_gnt", 32'(bus.dbg_gnt_o), 32'((i % 5) == 4));
            nextCycle();
        end
        applyIdle();
        nextCycle();

        // Debug gives up while promoted: core is served and priority drops back.
        applyStimulus(1'b1, 1'b0, 4'h0, 12'h100, 32'h0, 1'b1, 1'b0, 4'h0, 12'h104, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) nextCycle();
        applyStimulus(1'b1, 1'b0, 4'h0, 12'h100, 32'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("drop_state", 32'(bus.arb_state_o), 32'd1);
        checkOutput("drop_core_gnt", 32'(bus.core_gnt_o), 32'd1);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkOutput("drop_state_after", 32'(bus.arb_state_o), 32'd0);
        nextCycle();

        // Interleaved reads from alternating ports.
        applyStimulus(1'b1, 1'b0, 4'h0, 12'h020, 32'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("il_core_gnt", 32'(bus.core_gnt_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 1'b0, 4'h0, 12'h024, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("il_dbg_gnt", 32'(bus.dbg_gnt_o), 32'd1);
        checkOutput("il_core_rdata0", bus.core_rdata_o, 32'hA5A50008);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'h0, 12'h028, 32'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("il_dbg_rdata", bus.dbg_rdata_o, 32'hA5A50009);
        checkOutput("il_core_rvalid_off", 32'(bus.core_rvalid_o), 32'd0);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkOutput("il_core_rdata1", bus.core_rdata_o, 32'hA5A5000A);
        checkOutput("il_dbg_rvalid_off", 32'(bus.dbg_rvalid_o), 32'd0);
        nextCycle();

        // Lock: core starved out until lock is released; last debug write lands as lock drops.
        for (int j = 0; j < 12; j++) begin
            if (j == 0)
                applyStimulus(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 1'b0, 4'h0, 12'h030, 32'h0, 1'b1);
            else if (j == 3)
                applyStimulus(1'b1, 1'b0, 4'h0, 12'h040, 32'h0, 1'b1, 1'b1, 4'h3, 12'h044, 32'h12345678, 1'b1);
            else if (j == 10)
                applyStimulus(1'b1, 1'b0, 4'h0, 12'h040, 32'h0, 1'b1, 1'b1, 4'hF, 12'h048, 32'hCAFEF00D, 1'b0);
            else
                applyStimulus(1'b1, 1'b0, 4'h0, 12'h040, 32'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, j < 10);
            @(negedge clk);
            if (j == 0) begin
                checkOutput("lock_entry_dbg_gnt", 32'(bus.dbg_gnt_o), 32'd1);
            end else if (j <= 10) begin
                checkOutput("lock_state", 32'(bus.arb_state_o), 32'd2);
                checkOutput("lock_core_gnt", 32'(bus.core_gnt_o), 32'd0);
                if (j == 3 || j == 10) checkOutput("lock_dbg_gnt", 32'(bus.dbg_gnt_o), 32'd1);
            end else begin
                checkOutput("unlock_core_gnt", 32'(bus.core_gnt_o), 32'd1);
                checkOutput("unlock_state", 32'(bus.arb_state_o), 32'd0);
            end
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b1, 1'b0, 4'h0, 12'h044, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("be_dbg_gnt", 32'(bus.dbg_gnt_o), 32'd1);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkOutput("be_dbg_rdata", bus.dbg_rdata_o, 32'hA5A55678);
        nextCycle();

        // Reset arrives while a read is in flight.
        applyStimulus(1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rr_core_gnt", 32'(bus.core_gnt_o), 32'd1);
        nextCycle();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rr_core_rvalid", 32'(bus.core_rvalid_o), 32'd0);
        checkOutput("rr_core_rdata", bus.core_rdata_o, 32'd0);
        checkOutput("rr_dbg_rvalid", 32'(bus.dbg_rvalid_o), 32'd0);
        checkOutput("rr_core_gnt_low", 32'(bus.core_gnt_o), 32'd0);
        checkOutput("rr_mem_en", 32'(bus.mem_en_o), 32'd0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rr_post_state", 32'(bus.arb_state_o), 32'd0);
        checkOutput("rr_post_core_gnt", 32'(bus.core_gnt_o), 32'd1);
        nextCycle();
        applyIdle();
        @(negedge clk);
        checkOutput("rr_post_rdata", bus.core_rdata_o, 32'hDEADBEEF);
        nextCycle();
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/friscv_dmem_arbiter.md
# friscv_dmem_arbiter

Shares the single-port synchronous data memory (DMEM) between the pipeline's MEM stage (core port) and the debug/program-loader port. Grants are issued combinationally in the request cycle, so an uncontended core access costs no extra cycles. Read data returns one cycle later and is routed to the port that issued the read. A starvation counter and a lock mode sequence access to the shared resource; a denied core grant is the MEM-stage stall source.

## Interface
Parameters:
- ADDR_WIDTH, 12, byte address width (matches DMEM byte depth of 4096)
- DATA_WIDTH, 32, data width (ARCH)
- STARVE_LIMIT, 4, consecutive denied debug-request cycles before debug is forced to priority; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req_i / dbg_req_i  in  1  access request, per port
- core_we_i / dbg_we_i  in  1  1 = write, 0 = read
- core_be_i / dbg_be_i  in  DATA_WIDTH/8  byte enables (writes only)
- core_addr_i / dbg_addr_i  in  ADDR_WIDTH  byte address
- core_wdata_i / dbg_wdata_i  in  DATA_WIDTH  write data
- core_gnt_o / dbg_gnt_o  out  1  request accepted this cycle
- core_rvalid_o / dbg_rvalid_o  out  1  read data valid on this port
- core_rdata_o / dbg_rdata_o  out  DATA_WIDTH  read data (0 when rvalid low)
- dbg_lock_i  in  1  debug requests exclusive ownership of DMEM
- mem_en_o  out  1  DMEM access enable
- mem_we_o  out  1  DMEM write enable
- mem_be_o  out  DATA_WIDTH/8  DMEM byte enables
- mem_addr_o  out  ADDR_WIDTH  DMEM address
- mem_wdata_o  out  DATA_WIDTH  DMEM write data
- mem_rdata_i  in  DATA_WIDTH  DMEM read data, valid one cycle after a read enable
- arb_state_o  out  2  current FSM state (status/debug)

## Operation
- Handshake: a transfer occurs on a port in a cycle with req=1 and gnt=1. Once raised, req and its attributes hold stable until granted. Requests are never dropped.
- Only one gnt is high per cycle. The mem_* outputs mirror the granted port's attributes. mem_en_o equals the OR of the gnts. When nothing is granted, all mem_* outputs are 0.
- FSM state encoding: CORE_PRI = 0, DBG_PRI = 1, DBG_LOCK = 2.
- CORE_PRI:
  - Core wins when both ports request.
  - Debug is granted when the core is not requesting.
  - Goes to DBG_PRI when starve_cnt reaches STARVE_LIMIT.
  - Goes to DBG_LOCK on a debug transfer with dbg_lock_i=1.
- DBG_PRI:
  - Debug wins. Core is granted only if debug is not requesting.
  - After a debug transfer, goes to DBG_LOCK if dbg_lock_i=1, otherwise to CORE_PRI.
  - Goes to CORE_PRI if dbg_req_i falls before any transfer.
- DBG_LOCK:
  - core_gnt_o is held at 0. Debug is granted whenever it requests.
  - Goes to CORE_PRI in the cycle after dbg_lock_i is sampled low.
- starve_cnt (4 bits):
  - Increments in each cycle with dbg_req_i=1 and dbg_gnt_o=0, saturating at STARVE_LIMIT.
  - Clears on any debug transfer, when dbg_req_i=0, and on entry to DBG_LOCK.
- Read routing:
  - A registered owner flag records which port made an accepted read.
  - On the next cycle, that port's rvalid is 1 and its rdata equals mem_rdata_i. The other port's rvalid=0 and rdata=0.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating ports are routed correctly.

## Timing
- Grant latency: 0 cycles (combinational from req and state).
- Read latency: rvalid exactly 1 cycle after the granting edge. Throughput is 1 access per cycle.
- Worst-case debug wait under continuous core traffic: STARVE_LIMIT+1 cycles from req to gnt.
- Reset (asynchronous assert, synchronous-to-clk release):
  - State is CORE_PRI, starve_cnt=0, owner/rvalid registers are 0.
  - While rst_n=0, every output is 0, including gnts and mem_*.
  - A read in flight when reset asserts is discarded and no rvalid follows.
- Simultaneous events:
  - When lock entry and starvation saturation coincide, DBG_LOCK wins.
  - When dbg_lock_i drops in a cycle with a debug transfer, that transfer completes and the state returns to CORE_PRI.

## Test plan
- Core-only reads/writes, no debug traffic: core write to 0x010 with be=0xF, data 0xDEADBEEF, then read 0x010 -> gnt in the same cycle each time, core_rvalid_o one cycle after the read, core_rdata_o=0xDEADBEEF, dbg_rvalid_o=0.
- Both ports requesting continuously with STARVE_LIMIT=4 -> core granted cycles 0-3, debug granted cycle 4, core granted cycle 5, and the pattern repeats every 5 cycles.
- Interleaved reads core(0x020), dbg(0x024), core(0x028) on consecutive cycles -> each rvalid asserts on the correct port one cycle after its grant, with matching data and no cross-talk.
- Debug transfer with dbg_lock_i=1, core requesting throughout -> arb_state_o=2 and core_gnt_o=0 for 10 cycles. dbg_lock_i is dropped at cycle 10 -> core_gnt_o=1 at cycle 11.
- rst_n asserted in the cycle after a granted read -> no rvalid on either port, all outputs 0 during reset. After release, arb_state_o=0 and the core is granted on its first request.
